// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side logic: read latency,
// output-buffer state encodings and the packet beat-counter width.
package fifo_pkg;

    // Cycles from fifo_rd_en to valid fifo_rd_data.
    localparam int FIFO_RD_LATENCY = 1;

    // Width of the optional packet beat counter.
    localparam int CNT_W = 16;

    // Output buffer occupancy; the encoding doubles as the word count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/fifo_rdr_skid.sv
// fifo_rdr_skid: 2-entry register buffer in front of a valid/ready output.
// head_o is the oldest word; occ_o is the number of buffered words.
// A push into a full buffer is ignored unless a pop happens in the same cycle.
module fifo_rdr_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,        // asynchronous, active-high
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       occ_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i & (state_q != ST_EMPTY);
    assign do_push = push_i & ((state_q != ST_TWO) | do_pop);

    // Occupancy state register.
    // NOTE: sequential blocks use <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Occupancy next-state from push/pop.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (do_push) state_d = ST_ONE;
            ST_ONE: begin
                if (do_push && !do_pop)      state_d = ST_TWO;
                else if (do_pop && !do_push) state_d = ST_EMPTY;
            end
            ST_TWO:   if (do_pop && !do_push) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Slot next values: the head always holds the oldest word.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        case (state_q)
            ST_EMPTY: if (do_push) head_d = push_data_i;
            ST_ONE: begin
                if (do_push) begin
                    if (do_pop) head_d = push_data_i;  // new word slides in behind the departing one
                    else        tail_d = push_data_i;
                end
            end
            ST_TWO: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (do_push) tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Data slot registers.
    // NOTE: the slots are reset as well so the output word reads 0 out of reset, never X.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_o = head_q;
    assign occ_o  = state_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains the synchronous FIFO read port into a
// valid/ready stream through a 2-entry buffer, one word per cycle when the
// consumer keeps m_ready high. A pop is only issued when the buffer is
// guaranteed room for the word arriving one cycle later.
// Optional feature macro FIFO_RDR_TLAST_EN: builds a beat counter and drives
// m_last on every PKT_LEN-th beat; without it m_last is tied 0.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,        // asynchronous, active-high
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
);

    // The single inflight flag below only covers a one-cycle read port.
    if (FIFO_RD_LATENCY != 1) begin : g_bad_latency
        $error("fifo_stream_reader supports FIFO_RD_LATENCY == 1 only");
    end
    if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_pkt_len
        $error("fifo_stream_reader: PKT_LEN must be in 1..65535");
    end

    logic       inflight_q, inflight_d;
    logic [1:0] occ;
    logic       fire;
    logic [2:0] level;

    assign m_valid = (occ != 2'd0);
    assign fire    = m_valid & m_ready;

    // Words that will be held after this cycle if we do not pop now.
    assign level      = 3'(occ) + 3'(inflight_q) - 3'(fire);
    assign fifo_rd_en = ~rst_n & ~fifo_empty & (level < 3'd2);
    assign inflight_d = fifo_rd_en;

    // A pop this cycle means read data to capture next cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) inflight_q <= 1'b0;
        else       inflight_q <= inflight_d;
    end

    fifo_rdr_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data),
        .pop_i       (fire),
        .head_o      (m_data),
        .occ_o       (occ)
    );

    assign busy = inflight_q | m_valid;

`ifdef FIFO_RDR_TLAST_EN
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Beat counter advances on each fire and wraps after the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (fire) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end

    // Beat counter register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign m_last = m_valid & (cnt_q == LAST_BEAT);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A behavioural FIFO (queue) feeds
// the read port; every word written is pushed with its expected m_last into a
// scoreboard; a negedge monitor pops and compares on every fire and checks
// busy, hold-while-stalled and the 2-word bound on words taken but not yet sent.
module tb_fifo_stream_reader;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy)
    );

    // Reference model state
    logic [WIDTH-1:0] src_q[$];     // behavioural FIFO contents
    beat_t            exp_q[$];     // scoreboard of expected beats
    int               issue_idx  = 0;
    int               outstanding = 0;  // popped from FIFO, not yet fired
    int               fires = 0;
    int               pops  = 0;
    logic             pop_pending = 1'b0;
    int               ready_mode = 0;   // 0 always, 1 never, 2 toggle, 3 random
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic put(input logic [WIDTH-1:0] w);
        beat_t e;
        e.data = w;
`ifdef FIFO_RDR_TLAST_EN
        e.last = ((issue_idx % PKT_LEN) == PKT_LEN - 1);
`else
        e.last = 1'b0;
`endif
        src_q.push_back(w);
        exp_q.push_back(e);
        issue_idx++;
        fifo_empty = 1'b0;
    endtask

    // Advance one cycle: serve the FIFO pop seen last cycle, update inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending && src_q.size() > 0) fifo_rd_data = src_q.pop_front();
        fifo_empty = (src_q.size() == 0);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            2:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_words_left", exp_q.size(), 0);
        repeat (2) tick();
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
            pop_pending = 1'b0;
        end else begin
            check("busy", busy, outstanding != 0);
            check("pop_when_empty", fifo_rd_en & fifo_empty, 1'b0);
            if (!m_valid) check("last_without_valid", m_last, 1'b0);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                fires++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word (t=%0t)", m_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e.data);
                    check("last", m_last, e.last);
                end
            end
            pop_pending = fifo_rd_en & ~fifo_empty;
            if (pop_pending) pops++;
            outstanding = outstanding + int'(pop_pending) - int'(m_valid & m_ready);
            check("held_le_2", outstanding <= 2, 1'b1);
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w0;
        int               p0;
        int               f0;
        logic             t1_rd[6];
        logic             t1_vld[6];
        logic             t1_busy[6];
        logic [WIDTH-1:0] t1_data[6];
        t1_rd   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t1_vld  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        t1_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t1_data = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 8'h00);
        check("rst_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b0;
        ready_mode = 0;
        repeat (2) tick();

        // Three preloaded words, consumer always ready: cycle-exact latency
        put(8'h11);
        put(8'h22);
        put(8'h33);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t1_rd_en_c%0d", c), fifo_rd_en, t1_rd[c]);
            check($sformatf("t1_valid_c%0d", c), m_valid, t1_vld[c]);
            check($sformatf("t1_busy_c%0d", c), busy, t1_busy[c]);
            if (t1_vld[c]) check($sformatf("t1_data_c%0d", c), m_data, t1_data[c]);
            tick();
        end
        wait_drain(20);

        // Stalled consumer: only two pops, then release
        ready_mode = 1;
        tick();
        p0 = pops;
        w0 = 8'($urandom);
        put(w0);
        for (int i = 0; i < 3; i++) put(8'($urandom));
        repeat (6) tick();
        @(negedge clk);
        check("stall_pops", pops - p0, 2);
        check("stall_rd_en", fifo_rd_en, 1'b0);
        check("stall_fifo_left", src_q.size(), 2);
        check("stall_valid", m_valid, 1'b1);
        check("stall_head", m_data, w0);
        ready_mode = 0;
        wait_drain(40);

        // Toggling ready with the FIFO kept non-empty over 64 words
        ready_mode = 2;
        for (int i = 0; i < 64; i++) put(8'($urandom));
        wait_drain(400);

        // Random arrivals and random ready
        ready_mode = 3;
        for (int i = 0; i < 300; i++) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                put(8'($urandom));
                if ($urandom_range(0, 3) == 0) put(8'($urandom));
            end
        end
        ready_mode = 0;
        wait_drain(200);

        // Single word: one pop, one fire
        p0 = pops;
        f0 = fires;
        put(8'hA5);
        repeat (6) tick();
        @(negedge clk);
        check("single_pops", pops - p0, 1);
        check("single_fires", fires - f0, 1);

        // Reset with a full buffer and words still in the FIFO
        ready_mode = 1;
        tick();
        for (int i = 0; i < 4; i++) put(8'($urandom));
        repeat (5) tick();
        rst_n = 1'b1;
        src_q.delete();
        exp_q.delete();
        issue_idx  = 0;
        fifo_empty = 1'b1;
        #1;
        check("midrst_valid", m_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", m_data, 8'h00);
        f0 = fires;
        ready_mode = 0;
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("post_rst_fires", fires - f0, 0);
        check("post_rst_valid", m_valid, 1'b0);

        // Ten words after reset: beat count restarts from 0
        for (int i = 0; i < 10; i++) put(8'(i + 1));
        wait_drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
